data_cache: RTL
===============

# data_cache

Direct-mapped, write-through, no-write-allocate data cache sitting between the pipelined CPU's data-memory port and the word-addressed data memory. It answers CPU `d_readM`/`d_writeM` requests, fills 4-word lines from memory on read misses, and drives `cacheStall` back to the CPU while a request is outstanding. Hit and miss counters are exported for performance runs.

## Interface
- `NUM_LINES`, 4: number of lines, power of two; index width `IW = log2(NUM_LINES)`.
- `WORDS_PER_LINE`, 4: fixed at 4; offset width is 2.
- `Clk` input 1: single clock; all state updates on rising edge.
- `Reset` input 1: synchronous, active-high.
- `d_readM` input 1: CPU read request, level, held while `cacheStall`=1.
- `d_writeM` input 1: CPU write request, level, held while `cacheStall`=1.
- `d_address` input 16: CPU word address.
- `d_wdata` input 16: CPU write data.
- `d_rdata` output 16: read data; valid when `d_readM`=1 and `cacheStall`=0.
- `cacheStall` output 1: freeze request to the CPU pipeline.
- `mem_readM` output 1: line-fetch request to memory.
- `mem_writeM` output 1: word-write request to memory.
- `mem_address` output 16: line base (`{tag,index,2'b00}`) for reads; full word address for writes.
- `mem_wdata` output 16: write data, equal to `d_wdata`.
- `mem_rdata` input 64: fetched line; word k at bits [16k+15:16k].
- `mem_ready` input 1: one-cycle completion pulse from memory.
- `hit_count` output 16: completed hits.
- `miss_count` output 16: misses.

## Operation
- Address split: offset = `d_address[1:0]`, index = `d_address[IW+1:2]`, tag = the remaining upper bits. Storage per line: valid bit, tag, 4×16 data.
- `hit` = `valid[index]` and stored tag equals the address tag; this is combinational.
- Write priority: if `d_readM` and `d_writeM` are both 1, the access is treated as a write and the read is ignored.
- FSM states: IDLE, FETCH, FILL, WRITE.
- IDLE, read hit: `d_rdata` = the addressed word, `cacheStall`=0, and the FSM stays in IDLE.
- IDLE, read miss: `cacheStall`=1 and the FSM moves to FETCH.
- IDLE, write (hit or miss): `cacheStall`=1 and the FSM moves to WRITE.
- FETCH: `mem_readM`=1 and `mem_address` = the line base. On `mem_ready`, latch `mem_rdata` and move to FILL.
- FILL: write the latched line, the tag, and valid=1 into the indexed line, then move to IDLE. The next IDLE cycle is a hit and returns the data.
- WRITE: `mem_writeM`=1 and `mem_address` = `d_address`.
  - On `mem_ready`: `cacheStall`=0 in that same cycle, and the FSM moves to IDLE at the edge.
  - If hit, the addressed word in the line is updated at that same edge. On a miss the line is left unchanged.
- `cacheStall` is 1 when:
  - in IDLE with a read miss or any write, or
  - in FETCH or FILL, or
  - in WRITE without `mem_ready`.
- `cacheStall` is 0 otherwise, and always 0 while `Reset`=1.
- `d_rdata` is 16'h0000 whenever it is not a read hit.
- `mem_readM`/`mem_writeM` are decoded from the state only (Moore). `mem_ready` is ignored in IDLE and FILL.
- Counters: 16-bit, wrap from 16'hFFFF to 0.
  - `miss_count` increments on the IDLE→FETCH transition, and on a WRITE completion that was a miss.
  - `hit_count` increments on an IDLE read hit that is not the first cycle after FILL (tracked by a one-cycle `refilled` flag), and on a WRITE completion that was a hit.
  - Hence a read miss counts exactly one miss and zero hits.

## Timing
- Reset (synchronous): state=IDLE, all valid bits=0, counters=0, `refilled`=0. Outputs `cacheStall`, `mem_readM`, `mem_writeM` = 0 and `d_rdata` = 0 in the cycle after the reset edge. Reset asserted in FETCH/WRITE abandons the transfer; any `mem_ready` arriving afterwards is ignored.
- Read hit: 0 extra cycles; data is available in the request cycle.
- Read miss: stall cycles = 1 (IDLE) + N (FETCH, until `mem_ready`) + 1 (FILL). Data is returned in the following IDLE cycle. With `mem_ready` in the first FETCH cycle, the total stall is 3 cycles.
- Write: stall lasts until `mem_ready`. If `mem_ready` arrives in the first WRITE cycle, the stall is 1 cycle (the IDLE cycle only).
- Consecutive requests: a new request may be presented in the cycle after `cacheStall` falls. There is no bubble beyond the rules above.
- Conflict miss: a fill overwrites the indexed line regardless of its prior tag. No writeback is needed because the cache is write-through.

## Test plan
- Reset, then read 16'h0013 with memory returning line 16'hA000..A003 after 2 cycles -> `cacheStall`=1 for 4 cycles, then `d_rdata`=16'hA003, `miss_count`=1, `hit_count`=0.
- Read 16'h0011 immediately after -> no stall, `d_rdata`=16'hA001, `hit_count`=1.
- Write 16'h5555 to 16'h0012 (hit), then read 16'h0012 -> `mem_writeM` with address 16'h0012, read returns 16'h5555 with no stall, `hit_count`=3.
- Write to 16'h0040 (miss), then read 16'h0040 -> write does not allocate (`miss_count` +1), and the read misses and fetches.
- Read 16'h0013 then 16'h0053 (same index, different tag) -> both miss; re-reading 16'h0013 misses again.
- Assert `Reset` during FETCH, then deliver `mem_ready` -> FSM stays in IDLE, the line remains invalid, counters=0.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
// Sits between the CPU data port and a word-addressed memory that returns
// whole 4-word lines on reads and accepts single-word writes.
module data_cache #(
  parameter int NUM_LINES      = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         d_readM,
  input  logic                         d_writeM,
  input  logic [15:0]                  d_address,
  input  logic [15:0]                  d_wdata,
  output logic [15:0]                  d_rdata,
  output logic                         cacheStall,
  output logic                         mem_readM,
  output logic                         mem_writeM,
  output logic [15:0]                  mem_address,
  output logic [15:0]                  mem_wdata,
  input  logic [16*WORDS_PER_LINE-1:0] mem_rdata,
  input  logic                         mem_ready,
  output logic [15:0]                  hit_count,
  output logic [15:0]                  miss_count
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int TW = 16 - IW - OW;
  localparam int LW = 16 * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FILL  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_refilled;
  logic [LW-1:0]   r_line;
  logic [15:0]     r_hit_count;
  logic [15:0]     r_miss_count;

  // Line storage: valid, tag and data per line
  logic            r_valid [NUM_LINES];
  logic [TW-1:0]   r_tag   [NUM_LINES];
  logic [LW-1:0]   r_data  [NUM_LINES];

  logic [OW-1:0]   w_offset;
  logic [IW-1:0]   w_index;
  logic [TW-1:0]   w_tag;
  logic            w_hit;
  logic            w_req_wr;
  logic            w_req_rd;
  logic            w_read_hit;
  logic [LW-1:0]   w_sel_line;
  logic [15:0]     w_sel_word;
  logic            w_fill;
  logic            w_write_upd;

  assign w_offset = d_address[OW-1:0];
  assign w_index  = d_address[IW+OW-1:OW];
  assign w_tag    = d_address[15:IW+OW];

  // A simultaneous read and write is treated as a write only
  assign w_req_wr = d_writeM;
  assign w_req_rd = d_readM & ~d_writeM;

  assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_sel_line = r_data[w_index];
  assign w_sel_word = w_sel_line[{w_offset, 4'b0000} +: 16];

  // Only an IDLE-state read that hits produces data; gated by reset too
  assign w_read_hit = (r_state == S_IDLE) && w_req_rd && w_hit && !Reset;
  assign d_rdata    = w_read_hit ? w_sel_word : 16'h0000;

  assign w_fill      = (r_state == S_FILL);
  assign w_write_upd = (r_state == S_WRITE) && mem_ready && w_hit;

  // Stall the CPU whenever a request cannot be completed this cycle
  always_comb begin
    cacheStall = 1'b0;
    case (r_state)
      S_IDLE:  cacheStall = w_req_wr | (w_req_rd & ~w_hit);
      S_FETCH: cacheStall = 1'b1;
      S_FILL:  cacheStall = 1'b1;
      S_WRITE: cacheStall = ~mem_ready;
      default: cacheStall = 1'b0;
    endcase
    if (Reset) begin
      cacheStall = 1'b0;
    end
  end

  // Line fetches use the line base; word writes use the full address
  assign mem_address = (r_state == S_FETCH) ? {d_address[15:OW], {OW{1'b0}}} : d_address;
  assign mem_wdata   = d_wdata;
  assign mem_readM   = r_mem_read;
  assign mem_writeM  = r_mem_write;
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
      // Valid and tag of one line: cleared on reset, set by a fill
      always_ff @(posedge Clk) begin
        if (Reset) begin
          r_valid[gi] <= 1'b0;
          r_tag[gi]   <= '0;
        end else if (w_fill && (w_index == IW'(gi))) begin
          r_valid[gi] <= 1'b1;
          r_tag[gi]   <= w_tag;
        end
      end

      // Data of one line: whole-line fill, or single-word update on a write hit
      always_ff @(posedge Clk) begin
        if (!Reset) begin
          if (w_fill && (w_index == IW'(gi))) begin
            r_data[gi] <= r_line;
          end else if (w_write_upd && (w_index == IW'(gi))) begin
            r_data[gi][{w_offset, 4'b0000} +: 16] <= d_wdata;
          end
        end
      end
    end
  endgenerate

  // Controller FSM with registered memory strobes and performance counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_refilled   <= 1'b0;
      r_line       <= '0;
      r_hit_count  <= 16'h0000;
      r_miss_count <= 16'h0000;
    end else begin
      // The first IDLE cycle after a fill re-reads the fresh line; that
      // access was already counted as a miss
      r_refilled <= (r_state == S_FILL);
      case (r_state)
        S_IDLE: begin
          if (w_req_wr) begin
            r_state     <= S_WRITE;
            r_mem_write <= 1'b1;
          end else if (w_req_rd && !w_hit) begin
            r_state      <= S_FETCH;
            r_mem_read   <= 1'b1;
            r_miss_count <= r_miss_count + 16'd1;
          end else if (w_req_rd && w_hit && !r_refilled) begin
            r_hit_count <= r_hit_count + 16'd1;
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            r_line     <= mem_rdata;
            r_state    <= S_FILL;
            r_mem_read <= 1'b0;
          end
        end
        S_FILL: begin
          r_state <= S_IDLE;
        end
        S_WRITE: begin
          if (mem_ready) begin
            r_state     <= S_IDLE;
            r_mem_write <= 1'b0;
            if (w_hit) begin
              r_hit_count <= r_hit_count + 16'd1;
            end else begin
              r_miss_count <= r_miss_count + 16'd1;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
